// File: rtl/plu_pkg.sv
// Shared types and constants for the program loader.
// PLU_CHECKSUM_EN adds the CHECK state for the trailing XOR checksum byte.
package plu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] LEN_ZERO = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
`ifdef PLU_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } plu_state_e;

  // States in which the stream link accepts bytes.
  function automatic logic accepts_bytes(input plu_state_e st);
    return (st == ST_LEN) || (st == ST_DATA)
`ifdef PLU_CHECKSUM_EN
           || (st == ST_CHECK)
`endif
           ;
  endfunction

endpackage

// File: rtl/plu_checksum.sv
// 8-bit XOR accumulator over the data bytes of one frame, with a compare port.
module plu_checksum
  import plu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] cmp_byte,
  output logic              match_c
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // Clear wins over accumulate so a new frame always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match_c = (cmp_byte == acc_q);

endmodule

// File: rtl/program_loader_unit.sv
// Loads a LEN-prefixed byte stream into instruction memory, then releases the CPU.
// PLU_CHECKSUM_EN: a trailing XOR checksum byte must match before the CPU runs.
module program_loader_unit
  import plu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  plu_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer_c;
  logic              len_bad_c;
  logic              last_c;

  assign xfer_c    = in_valid & ready_q;
  assign len_bad_c = (in_data == LEN_ZERO) || (32'(in_data) > DEPTH);
  assign last_c    = (cnt_q == (len_q - CNT_W'(1)));

`ifdef PLU_CHECKSUM_EN
  logic chk_clr;
  logic chk_en;
  logic chk_match_c;

  plu_checksum u_checksum (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (chk_clr),
    .en       (chk_en),
    .din      (in_data),
    .cmp_byte (in_data),
    .match_c  (chk_match_c)
  );
`endif

  // Next state, counters and the registered write port.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PLU_CHECKSUM_EN
    chk_clr = 1'b0;
    chk_en  = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (xfer_c) begin
          if (len_bad_c) begin
            state_d = ST_ERROR;
          end else begin
            len_d   = CNT_W'(in_data);
            cnt_d   = '0;
            state_d = ST_DATA;
`ifdef PLU_CHECKSUM_EN
            chk_clr = 1'b1;
`endif
          end
        end
      end

      ST_DATA: begin
        if (xfer_c) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = in_data;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef PLU_CHECKSUM_EN
          chk_en  = 1'b1;
          if (last_c) begin
            state_d = ST_CHECK;
          end
`else
          if (last_c) begin
            state_d = ST_RUN;
          end
`endif
        end
      end

`ifdef PLU_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer_c) begin
          state_d = chk_match_c ? ST_RUN : ST_ERROR;
        end
      end
`endif

      ST_RUN, ST_ERROR: begin
        if (load_start) begin
          state_d = ST_LEN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs follow the state being entered, so they change on the same edge.
  always_comb begin
    ready_d = accepts_bytes(state_d);
    run_d   = (state_d == ST_RUN);
    done_d  = (state_d == ST_RUN);
    err_d   = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_program_loader_unit.sv
// Randomized bench for program_loader_unit against a frame-level reference model.
// Honours PLU_CHECKSUM_EN the same way as the design.
module tb_program_loader_unit;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;
`ifdef PLU_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_run;
  logic              load_done;
  logic              load_error;

  always #5 clock = ~clock;

  program_loader_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_error (load_error)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "reset";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Reference model: progress through a frame, tracked as bytes remaining.
  bit         m_busy, m_want_len, m_want_chk;
  int         m_left, m_idx;
  logic [7:0] m_acc;
  bit         e_run, e_done, e_err, e_we;
  int         e_addr;
  logic [7:0] e_wdata;
  int         n_writes;

  task automatic model_reset();
    m_busy = 0; m_want_len = 0; m_want_chk = 0;
    m_left = 0; m_idx = 0; m_acc = 8'h00;
    e_run = 0; e_done = 0; e_err = 0; e_we = 0; e_addr = 0; e_wdata = 8'h00;
  endtask

  task automatic model_step(input bit ls, input bit v, input logic [7:0] d);
    bit xfer;
    xfer = v && m_busy;
    e_we = 0;
    if (!m_busy) begin
      if (ls) begin
        m_busy = 1; m_want_len = 1; m_want_chk = 0;
        e_run = 0; e_done = 0; e_err = 0;
      end
    end else if (xfer) begin
      if (m_want_len) begin
        m_want_len = 0;
        if (d == 8'h00 || int'(d) > DEPTH) begin
          m_busy = 0; e_err = 1;
        end else begin
          m_left = int'(d); m_idx = 0; m_acc = 8'h00;
        end
      end else if (m_want_chk) begin
        m_want_chk = 0; m_busy = 0;
        if (d == m_acc) begin e_run = 1; e_done = 1; end
        else e_err = 1;
      end else begin
        e_we = 1; e_addr = m_idx; e_wdata = d;
        m_idx++; m_left--; m_acc ^= d; n_writes++;
        if (m_left == 0) begin
          if (CHK_ON) m_want_chk = 1;
          else begin m_busy = 0; e_run = 1; e_done = 1; end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("in_ready", in_ready, m_busy);
    check_eq("cpu_run", cpu_run, e_run);
    check_eq("load_done", load_done, e_done);
    check_eq("load_error", load_error, e_err);
    check_eq("imem_we", imem_we, e_we);
    if (e_we) begin
      check_eq("imem_addr", imem_addr, e_addr);
      check_eq("imem_wdata", imem_wdata, e_wdata);
    end
  endtask

  task automatic check_all_zero();
    check_eq("rst.in_ready", in_ready, 0);
    check_eq("rst.cpu_run", cpu_run, 0);
    check_eq("rst.load_done", load_done, 0);
    check_eq("rst.load_error", load_error, 0);
    check_eq("rst.imem_we", imem_we, 0);
    check_eq("rst.imem_addr", imem_addr, 0);
    check_eq("rst.imem_wdata", imem_wdata, 0);
  endtask

  task automatic cycle(input bit ls, input bit v, input logic [7:0] d);
    load_start = ls; in_valid = v; in_data = d;
    @(posedge clock);
    model_step(ls, v, d);
    #1;
    check_outputs();
  endtask

  // Random idle gaps (with ignored load_start pulses while busy), then one valid beat.
  task automatic send_byte(input logic [7:0] d, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gaps) cycle(m_busy && ($urandom_range(3, 0) == 0), 1'b0, 8'($urandom));
    cycle(1'b0, 1'b1, d);
  endtask

  task automatic load_frame(input logic [7:0] len, input logic [7:0] data[$],
                            input logic [7:0] chk_mask, input int gap_max);
    logic [7:0] acc;
    acc = 8'h00;
    cycle(1'b1, 1'b0, 8'($urandom));
    send_byte(len, gap_max);
    foreach (data[i]) begin
      send_byte(data[i], gap_max);
      acc ^= data[i];
    end
    if (CHK_ON && len != 8'h00) send_byte(acc ^ chk_mask, gap_max);
    repeat (3) cycle(1'b0, 1'($urandom), 8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    int w0;
    model_reset();
    n_writes = 0;
    #1;
    check_all_zero();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    phase = "idle";
    repeat (3) cycle(1'b0, 1'b1, 8'h55);

    phase = "t1_basic";
    q = '{8'h21, 8'h42, 8'h63};
    w0 = n_writes;
    load_frame(8'd3, q, 8'h00, 0);
    check_eq("t1.writes", n_writes - w0, 3);
    check_eq("t1.cpu_run", cpu_run, 1);

    phase = "t2_len0";
    q = '{};
    w0 = n_writes;
    load_frame(8'h00, q, 8'h00, 1);
    check_eq("t2.writes", n_writes - w0, 0);
    check_eq("t2.load_error", load_error, 1);

`ifdef PLU_CHECKSUM_EN
    phase = "t3_badchk";
    q = '{8'hA0, 8'h05};
    load_frame(8'd2, q, 8'h01, 0);
    check_eq("t3.load_error", load_error, 1);
    check_eq("t3.cpu_run", cpu_run, 0);
    cycle(1'b1, 1'b0, 8'h00);
    check_eq("t3.cleared", load_error, 0);
    send_byte(8'd1, 0);
    send_byte(8'h5A, 0);
    send_byte(8'h5A, 0);
    check_eq("t3.recover", cpu_run, 1);
`endif

    phase = "t4_toggle";
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    w0 = n_writes;
    load_frame(8'd4, q, 8'h00, 3);
    check_eq("t4.writes", n_writes - w0, 4);

    phase = "t5_reset";
    cycle(1'b1, 1'b0, 8'h00);
    send_byte(8'd4, 0);
    send_byte(8'hC1, 1);
    send_byte(8'hC2, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    q = '{8'h01, 8'h02};
    load_frame(8'd2, q, 8'h00, 1);
    check_eq("t5.done", load_done, 1);

    phase = "t6_reload";
    q = '{8'hFF};
    w0 = n_writes;
    load_frame(8'd1, q, 8'h00, 0);
    check_eq("t6.writes", n_writes - w0, 1);
    check_eq("t6.cpu_run", cpu_run, 1);

    phase = "random";
    for (int f = 0; f < 30; f++) begin
      int len;
      logic [7:0] mask;
      case ($urandom_range(9, 0))
        0:       len = 0;
        1:       len = 255;
        default: len = int'($urandom_range(12, 1));
      endcase
      if (f == 7) len = 200;
      if (len == 255 && f != 3) len = 9;
      q = '{};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      mask = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      load_frame(8'(len), q, mask, int'($urandom_range(2, 0)));
    end

    phase = "final";
    check_eq("final.exclusive", load_done & load_error, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
